// File: rtl/bus_slot_pkg.sv
// Shared constants and types for the slotted single-wire receive bus.
// Build option: define BUS_SLOT_PARITY_EN to add one even-parity round per frame.
package bus_slot_pkg;

  localparam int N_SRC_DEFAULT = 4;
  localparam int W_DEFAULT     = 4;
  localparam int SEL_W         = $clog2(N_SRC_DEFAULT);

`ifdef BUS_SLOT_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  localparam int ROUNDS = W_DEFAULT + PARITY_BITS;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/slot_shift_reg.sv
// Serial-in shift register for one source's slot: W data bits plus the optional parity bit.
// Build option: BUS_SLOT_PARITY_EN widens the register by one bit.
module slot_shift_reg
  import bus_slot_pkg::*;
#(
  parameter  int W     = W_DEFAULT,
  localparam int DEPTH = W + PARITY_BITS
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             din,
  output logic [DEPTH-1:0] shift_next
);

  logic [DEPTH-1:0] shift_q;

  // The next value is exported so the top can publish the final bit in the same edge it lands.
  always_comb begin
    shift_next = load ? {shift_q[DEPTH-2:0], din} : shift_q;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_next;
    end
  end

endmodule

// File: rtl/bus_slot_receiver.sv
// Slot sequencer and deserialiser for a shared tri-state bus with N_SRC time-multiplexed sources.
// Build option: BUS_SLOT_PARITY_EN enables the per-source parity round and parity_err.
module bus_slot_receiver
  import bus_slot_pkg::*;
#(
  parameter  int N_SRC = N_SRC_DEFAULT,
  parameter  int W     = W_DEFAULT,
  localparam int SEL_W = $clog2(N_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               bus_line,
  output logic [SEL_W-1:0]   sel,
  output logic [N_SRC*W-1:0] data_out,
  output logic               frame_valid,
  output logic               busy,
  output logic [N_SRC-1:0]   parity_err
);

  localparam int FRAME_ROUNDS = W + PARITY_BITS;
  localparam int RND_W        = $clog2(FRAME_ROUNDS);

  logic [RND_W-1:0]        round;
  logic [FRAME_ROUNDS-1:0] shift_next [N_SRC];
  logic [N_SRC*W-1:0]      frame_word;
  logic                    last_slot;
  logic                    end_of_frame;
  logic                    shift_clr;
`ifdef BUS_SLOT_PARITY_EN
  logic [N_SRC-1:0]        frame_parity;
`endif

  assign shift_clr = rst || !enable;

  // Data bits occupy the top W bits of each register; a parity bit, if present, sits at bit 0.
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    slot_shift_reg #(.W(W)) u_shift (
      .clk        (clk),
      .clr        (shift_clr),
      .load       (enable && (sel == SEL_W'(gi))),
      .din        (bus_line),
      .shift_next (shift_next[gi])
    );
    assign frame_word[W*gi +: W] = shift_next[gi][FRAME_ROUNDS-1 -: W];
`ifdef BUS_SLOT_PARITY_EN
    assign frame_parity[gi] = ^shift_next[gi];
`endif
  end

  always_comb begin
    last_slot    = (sel == SEL_W'(N_SRC - 1));
    end_of_frame = last_slot && (round == RND_W'(FRAME_ROUNDS - 1));
  end

  // Dropping enable abandons the partial frame but keeps the last published frame visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel         <= '0;
      round       <= '0;
      busy        <= 1'b0;
      frame_valid <= 1'b0;
      data_out    <= '0;
`ifdef BUS_SLOT_PARITY_EN
      parity_err  <= '0;
`endif
    end else if (!enable) begin
      sel         <= '0;
      round       <= '0;
      busy        <= 1'b0;
      frame_valid <= 1'b0;
    end else if (end_of_frame) begin
      sel         <= '0;
      round       <= '0;
      busy        <= 1'b0;
      frame_valid <= 1'b1;
      data_out    <= frame_word;
`ifdef BUS_SLOT_PARITY_EN
      parity_err  <= frame_parity;
`endif
    end else begin
      sel         <= sel + SEL_W'(1);
      busy        <= 1'b1;
      frame_valid <= 1'b0;
      if (last_slot) begin
        round <= round + RND_W'(1);
      end
    end
  end

`ifndef BUS_SLOT_PARITY_EN
  assign parity_err = '0;
`endif

endmodule
